// File: rtl/noc_pkg.sv
// ----------------------------------------------------------------------------
// noc_pkg
// Shared NoC definitions: flit ID encodings, output port indices, the input
// unit FSM state type and the XY routing function used by router inputs.
// ----------------------------------------------------------------------------
package noc_pkg;

    // Flit IDs carried in the top bits of every flit
    localparam logic [1:0] SINGLE_ID = 2'b00;  // head and tail in one flit
    localparam logic [1:0] HEAD_ID   = 2'b01;
    localparam logic [1:0] BODY_ID   = 2'b10;
    localparam logic [1:0] TAIL_ID   = 2'b11;

    // Output port order of a 5-port mesh router
    localparam int unsigned PORT_LOCAL = 0;
    localparam int unsigned PORT_EAST  = 1;
    localparam int unsigned PORT_WEST  = 2;
    localparam int unsigned PORT_NORTH = 3;
    localparam int unsigned PORT_SOUTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ACTIVE = 2'd2
    } state_e;

    // Dimension-ordered routing: X is resolved completely before Y.
    function automatic int unsigned xy_route(
        input int unsigned dst_x,
        input int unsigned dst_y,
        input int unsigned cur_x,
        input int unsigned cur_y
    );
        int unsigned port;
        if (dst_x > cur_x)      port = PORT_EAST;
        else if (dst_x < cur_x) port = PORT_WEST;
        else if (dst_y > cur_y) port = PORT_NORTH;
        else if (dst_y < cur_y) port = PORT_SOUTH;
        else                    port = PORT_LOCAL;
        return port;
    endfunction

endpackage

// File: rtl/noc_input_unit_if.sv
// ----------------------------------------------------------------------------
// noc_input_unit_if
// Bundles the upstream flit link and the allocator/crossbar handshake of one
// router input port.
//   flit_i/vld_i/rdy_o       : upstream flit link
//   req_o/grant_i/oc_rdy_i   : allocator request, grant and output readiness
//   flit_o/vld_o/is_tail_o   : head-of-buffer flit toward the crossbar
//   err_o                    : stray non-header flit dropped
// slave modport is the input unit, master modport is its environment.
// ----------------------------------------------------------------------------
interface noc_input_unit_if #(
    parameter int FLIT_W = 10,
    parameter int OUT_N  = 5
);
    logic [FLIT_W-1:0] flit_i;
    logic              vld_i;
    logic              rdy_o;
    logic [OUT_N-1:0]  req_o;
    logic [OUT_N-1:0]  grant_i;
    logic [OUT_N-1:0]  oc_rdy_i;
    logic [FLIT_W-1:0] flit_o;
    logic              vld_o;
    logic              is_tail_o;
    logic              err_o;

    modport slave (
        input  flit_i, vld_i, grant_i, oc_rdy_i,
        output rdy_o, req_o, flit_o, vld_o, is_tail_o, err_o
    );

    modport master (
        output flit_i, vld_i, grant_i, oc_rdy_i,
        input  rdy_o, req_o, flit_o, vld_o, is_tail_o, err_o
    );
endinterface

// File: rtl/circ_fifo.sv
// ----------------------------------------------------------------------------
// circ_fifo
// Circular flit buffer without bypass. Pointers carry one extra wrap bit so
// full/empty come from comparing the MSBs.
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   wr_en_i, data_i    : push request and data (ignored while full)
//   rd_en_i            : pop request (ignored while empty)
//   data_o             : head entry, zero while empty
//   full_o, empty_o    : occupancy flags
// ----------------------------------------------------------------------------
module circ_fifo #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_push;
    logic w_pop;

    assign w_push = wr_en_i && !full_o;
    assign w_pop  = rd_en_i && !empty_o;

    // NOTE: state registers use non-blocking assignments so every always_ff
    // reads the pre-edge values of its neighbours, exactly like real flops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // NOTE: the storage array is deliberately not reset; clearing the pointers
    // already makes every entry invalid, and a reset would forbid RAM mapping.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= data_i;
    end

    assign empty_o = (r_wr_ptr == r_rd_ptr);
    assign full_o  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // Masked while empty so stale or uninitialised storage never shows up.
    assign data_o  = empty_o ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/noc_input_unit.sv
// ----------------------------------------------------------------------------
// noc_input_unit
// Router input port: buffers incoming flits, XY-routes the header at the head
// of the buffer, requests the chosen output allocator and streams the packet
// under grant and output backpressure until its tail leaves.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus (slave)   : upstream link flit_i/vld_i/rdy_o; allocator side
//                   req_o/grant_i/oc_rdy_i; crossbar side flit_o/vld_o/
//                   is_tail_o; err_o pulses when a stray flit is dropped
// ----------------------------------------------------------------------------
module noc_input_unit
    import noc_pkg::*;
#(
    parameter int          FLIT_W     = 10,
    parameter int          FLIT_ID_W  = 2,
    parameter int          COORD_W    = 2,
    parameter int unsigned X_CUR      = 0,
    parameter int unsigned Y_CUR      = 0,
    parameter int          FIFO_DEPTH = 4,
    parameter int          OUT_N      = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    noc_input_unit_if.slave       bus
);
    localparam logic [OUT_N-1:0] ROUTE_ONE = OUT_N'(1);

    logic [FLIT_W-1:0]    w_head;
    logic                 w_full;
    logic                 w_empty;
    logic [FLIT_ID_W-1:0] w_head_id;
    logic                 w_head_is_hdr;
    logic                 w_head_is_end;
    logic [COORD_W-1:0]   w_dst_x;
    logic [COORD_W-1:0]   w_dst_y;
    int unsigned          w_route_port;
    logic [OUT_N-1:0]     w_route_oh;
    logic                 w_busy;
    logic                 w_vld;
    logic                 w_xfer;
    logic                 w_tail_xfer;
    logic                 w_drop;

    state_e               r_state;
    logic [OUT_N-1:0]     r_route;
    logic                 r_err;

    circ_fifo #(
        .DATA_W (FLIT_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .wr_en_i (bus.vld_i),
        .data_i  (bus.flit_i),
        .rd_en_i (w_xfer || w_drop),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign w_head_id     = w_head[FLIT_W-1 -: FLIT_ID_W];
    assign w_head_is_hdr = (w_head_id == FLIT_ID_W'(HEAD_ID)) ||
                           (w_head_id == FLIT_ID_W'(SINGLE_ID));
    assign w_head_is_end = (w_head_id == FLIT_ID_W'(TAIL_ID)) ||
                           (w_head_id == FLIT_ID_W'(SINGLE_ID));

    assign w_dst_x      = w_head[COORD_W-1:0];
    assign w_dst_y      = w_head[2*COORD_W-1:COORD_W];
    assign w_route_port = xy_route(32'(w_dst_x), 32'(w_dst_y), X_CUR, Y_CUR);
    assign w_route_oh   = ROUTE_ONE << w_route_port;

    // A packet owns the output from the REQ decision until its tail leaves.
    assign w_busy      = (r_state != ST_IDLE);
    assign w_vld       = w_busy && !w_empty;
    // Grant bits for outputs other than the routed one are masked here.
    assign w_xfer      = w_vld && |(bus.grant_i & r_route & bus.oc_rdy_i);
    assign w_tail_xfer = w_xfer && w_head_is_end;
    // Body/tail at the head while no packet is open belongs to nothing.
    assign w_drop      = (r_state == ST_IDLE) && !w_empty && !w_head_is_hdr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_route <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        if (w_head_is_hdr) begin
                            r_route <= w_route_oh;
                            r_state <= ST_REQ;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    // Single-flit packets leave straight from REQ.
                    if (w_tail_xfer)                   r_state <= ST_IDLE;
                    else if (|(bus.grant_i & r_route)) r_state <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (w_tail_xfer) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.rdy_o     = !w_full;
    assign bus.req_o     = w_busy ? r_route : '0;
    assign bus.flit_o    = w_head;
    assign bus.vld_o     = w_vld;
    assign bus.is_tail_o = w_vld && w_head_is_end;
    assign bus.err_o     = r_err;

endmodule

// File: tb/tb_noc_input_unit.sv
// ----------------------------------------------------------------------------
// tb_noc_input_unit
// Directed bench for noc_input_unit at router (0,0). A queue-based model of
// the input port predicts every output each cycle; a small registered
// allocator answers requests one cycle later.
// ----------------------------------------------------------------------------
module tb_noc_input_unit;
    import noc_pkg::*;

    localparam int FLIT_W = 10;
    localparam int OUT_N  = 5;
    localparam int DEPTH  = 4;
    localparam int unsigned X_CUR = 0;
    localparam int unsigned Y_CUR = 0;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b1;

    noc_input_unit_if #(.FLIT_W(FLIT_W), .OUT_N(OUT_N)) bus ();

    noc_input_unit #(
        .FLIT_W     (FLIT_W),
        .FLIT_ID_W  (2),
        .COORD_W    (2),
        .X_CUR      (X_CUR),
        .Y_CUR      (Y_CUR),
        .FIFO_DEPTH (DEPTH),
        .OUT_N      (OUT_N)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    int n_pass   = 0;
    int n_checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- allocator: registered grant of the current request
    logic [OUT_N-1:0] alloc_en;
    logic [OUT_N-1:0] r_grant;
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_grant <= '0;
        else         r_grant <= bus.req_o & alloc_en;
    end
    assign bus.grant_i = r_grant;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // ---------------- behavioural model
    function automatic bit ends_pkt(input logic [FLIT_W-1:0] f);
        return (f[9:8] == 2'b11) || (f[9:8] == 2'b00);
    endfunction

    function automatic bit is_stray(input logic [FLIT_W-1:0] f);
        return (f[9:8] == 2'b10) || (f[9:8] == 2'b11);
    endfunction

    function automatic logic [OUT_N-1:0] model_route(input logic [FLIT_W-1:0] f);
        int unsigned dx;
        int unsigned dy;
        dx = f[1:0];
        dy = f[3:2];
        if (dx > X_CUR) return 5'b00010;
        if (dx < X_CUR) return 5'b00100;
        if (dy > Y_CUR) return 5'b01000;
        if (dy < Y_CUR) return 5'b10000;
        return 5'b00001;
    endfunction

    logic [FLIT_W-1:0] mq[$];
    bit               m_open  = 1'b0;
    logic [OUT_N-1:0] m_route = '0;
    bit               m_err   = 1'b0;
    int               m_n;
    bit               m_xfer, m_drop, m_start, m_full;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mq.delete();
            m_open  = 1'b0;
            m_route = '0;
            m_err   = 1'b0;
        end else begin
            m_n     = mq.size();
            m_full  = (m_n >= DEPTH);
            m_xfer  = m_open && (m_n > 0) && (|(bus.grant_i & m_route & bus.oc_rdy_i));
            m_drop  = !m_open && (m_n > 0) && is_stray(mq[0]);
            m_start = !m_open && (m_n > 0) && !is_stray(mq[0]);
            m_err   = m_drop;
            if (m_xfer) begin
                if (ends_pkt(mq[0])) m_open = 1'b0;
                void'(mq.pop_front());
            end
            if (m_drop) void'(mq.pop_front());
            if (m_start) begin
                m_open  = 1'b1;
                m_route = model_route(mq[0]);
            end
            if (bus.vld_i && !m_full) mq.push_back(bus.flit_i);
        end
    end

    // ---------------- compare process: every cycle, on the falling edge
    logic [FLIT_W-1:0] e_flit;
    bit                e_vld, e_tail;
    always @(negedge clk_i) begin
        e_vld  = m_open && (mq.size() > 0);
        e_flit = (mq.size() > 0) ? mq[0] : '0;
        e_tail = 1'b0;
        if (e_vld) e_tail = ends_pkt(mq[0]);
        check("rdy_o",     32'(bus.rdy_o),     32'(mq.size() < DEPTH));
        check("req_o",     32'(bus.req_o),     32'(m_open ? m_route : '0));
        check("vld_o",     32'(bus.vld_o),     32'(e_vld));
        check("flit_o",    32'(bus.flit_o),    32'(e_flit));
        check("is_tail_o", 32'(bus.is_tail_o), 32'(e_tail));
        check("err_o",     32'(bus.err_o),     32'(m_err));
    end

    // ---------------- transfer monitor
    logic [FLIT_W-1:0] out_q[$];
    bit                tail_q[$];
    int                xfer_cyc[$];
    int                err_cnt;
    int                req_first_cyc;
    logic [OUT_N-1:0]  req_seen;
    bit                saw_active;
    bit                prev_tail = 1'b0;

    always @(negedge clk_i) begin
        if (prev_tail) check("req_after_tail", 32'(bus.req_o), 32'd0);
        prev_tail = 1'b0;
        if (bus.vld_o && |(bus.grant_i & bus.req_o & bus.oc_rdy_i)) begin
            out_q.push_back(bus.flit_o);
            tail_q.push_back(bus.is_tail_o);
            xfer_cyc.push_back(cyc);
            prev_tail = bus.is_tail_o;
        end
        if (bus.err_o) err_cnt++;
        if (bus.req_o != '0 && req_seen == '0) req_first_cyc = cyc;
        req_seen |= bus.req_o;
        if (dut.r_state == ST_ACTIVE) saw_active = 1'b1;
    end

    // ---------------- stimulus helpers
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [FLIT_W-1:0] f);
        bus.flit_i = f;
        bus.vld_i  = 1'b1;
        tick();
        bus.vld_i  = 1'b0;
    endtask

    task automatic clear_mon();
        out_q.delete();
        tail_q.delete();
        xfer_cyc.delete();
        err_cnt       = 0;
        req_seen      = '0;
        req_first_cyc = -1;
        saw_active    = 1'b0;
    endtask

    task automatic wait_xfers(input int n, input string name);
        int k;
        k = 0;
        while (out_q.size() < n && k < 200) begin
            tick();
            k++;
        end
        check({name, "_xfer_count"}, 32'(out_q.size()), 32'(n));
    endtask

    task automatic expect_flits(input string name, input logic [FLIT_W-1:0] exp[4], input int n);
        for (int i = 0; i < n; i++) begin
            if (i < out_q.size()) check($sformatf("%s_flit%0d", name, i), 32'(out_q[i]), 32'(exp[i]));
            else                  check($sformatf("%s_flit%0d_missing", name, i), 32'(out_q.size()), 32'(n));
        end
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_rdy"},  32'(bus.rdy_o),     32'd1);
        check({name, "_req"},  32'(bus.req_o),     32'd0);
        check({name, "_vld"},  32'(bus.vld_o),     32'd0);
        check({name, "_tail"}, 32'(bus.is_tail_o), 32'd0);
        check({name, "_err"},  32'(bus.err_o),     32'd0);
        check({name, "_flit"}, 32'(bus.flit_o),    32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    logic [FLIT_W-1:0] exp_f[4];
    int                cyc_hdr;
    int                k;

    initial begin
        bus.flit_i   = '0;
        bus.vld_i    = 1'b0;
        bus.oc_rdy_i = '0;
        alloc_en     = '0;
        clear_mon();
        #1 rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check_reset_values("reset");
        rst_ni = 1'b1;
        tick();

        // 1: east packet head/body/tail, grant one cycle after request
        clear_mon();
        alloc_en     = '1;
        bus.oc_rdy_i = '1;
        push(10'h102);
        cyc_hdr = cyc;
        push(10'h255);
        push(10'h333);
        wait_xfers(3, "east");
        exp_f = '{10'h102, 10'h255, 10'h333, 10'h000};
        expect_flits("east", exp_f, 3);
        if (tail_q.size() == 3) begin
            check("east_tail0", 32'(tail_q[0]), 32'd0);
            check("east_tail2", 32'(tail_q[2]), 32'd1);
        end else check("east_tail_count", 32'(tail_q.size()), 32'd3);
        check("east_req", 32'(req_seen), 32'h02);
        check("east_req_latency", 32'(req_first_cyc - cyc_hdr), 32'd1);
        if (xfer_cyc.size() > 0) check("east_xfer_latency", 32'(xfer_cyc[0] - cyc_hdr), 32'd2);
        else check("east_xfer_latency_none", 32'(xfer_cyc.size()), 32'd1);
        repeat (3) tick();

        // 2: single-flit packet to the local port
        clear_mon();
        push(10'h0A0);
        wait_xfers(1, "single");
        exp_f = '{10'h0A0, 10'h000, 10'h000, 10'h000};
        expect_flits("single", exp_f, 1);
        if (tail_q.size() > 0) check("single_tail", 32'(tail_q[0]), 32'd1);
        check("single_req", 32'(req_seen), 32'h01);
        repeat (3) tick();
        check("single_no_active", 32'(saw_active), 32'd0);

        // 3: fill the buffer without grant, overflow flit must be dropped
        clear_mon();
        alloc_en = '0;
        push(10'h101);
        push(10'h2C1);
        push(10'h2C2);
        push(10'h3C3);
        check("fill_rdy_low", 32'(bus.rdy_o), 32'd0);
        push(10'h1F0);
        check("fill_rdy_still_low", 32'(bus.rdy_o), 32'd0);
        repeat (3) tick();
        alloc_en = '1;
        k = 0;
        while (out_q.size() < 1 && k < 50) begin
            tick();
            k++;
        end
        check("fill_rdy_after_pop", 32'(bus.rdy_o), 32'd1);
        wait_xfers(4, "fill");
        exp_f = '{10'h101, 10'h2C1, 10'h2C2, 10'h3C3};
        expect_flits("fill", exp_f, 4);
        repeat (6) tick();
        check("fill_overflow_not_stored", 32'(out_q.size()), 32'd4);
        check("fill_idle_req", 32'(bus.req_o), 32'd0);

        // 4: north packet with oc_rdy toggling every cycle
        clear_mon();
        bus.oc_rdy_i = '0;
        push(10'h104);
        push(10'h2D1);
        push(10'h2D2);
        push(10'h3D3);
        for (int i = 0; i < 24; i++) begin
            bus.oc_rdy_i[3] = (i % 2 == 0);
            tick();
        end
        bus.oc_rdy_i = '1;
        check("north_count", 32'(out_q.size()), 32'd4);
        exp_f = '{10'h104, 10'h2D1, 10'h2D2, 10'h3D3};
        expect_flits("north", exp_f, 4);
        check("north_req", 32'(req_seen), 32'h08);
        repeat (2) tick();

        // 5: stray body flit while idle
        clear_mon();
        push(10'h255);
        repeat (4) tick();
        check("stray_err_pulses", 32'(err_cnt), 32'd1);
        check("stray_req", 32'(req_seen), 32'd0);
        check("stray_no_xfer", 32'(out_q.size()), 32'd0);

        // 6: reset mid-packet, then a fresh packet
        clear_mon();
        bus.oc_rdy_i = '0;
        push(10'h102);
        push(10'h2E1);
        repeat (3) tick();
        #2 rst_ni = 1'b0;
        #1;
        check_reset_values("midreset");
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        clear_mon();
        bus.oc_rdy_i = '1;
        push(10'h10F);
        push(10'h3E5);
        wait_xfers(2, "post_reset");
        exp_f = '{10'h10F, 10'h3E5, 10'h000, 10'h000};
        expect_flits("post_reset", exp_f, 2);
        check("post_reset_req", 32'(req_seen), 32'h02);
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
